// File: rtl/apuf_crp_controller.sv
`default_nettype none
// ============================================================================
// Module      : apuf_crp_controller
// Description : Arbiter-PUF challenge/response sequencer with majority voting
//               and a valid/ready CRP output port.
// Revision    : 1.0 - initial release
// ============================================================================
module apuf_crp_controller #(
    parameter int N       = 32,
    parameter int SETTLE  = 8,
    parameter int REPS    = 5,
    parameter int NUM_CRP = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     c_bits_in,
    output logic [N-1:0]     chal_out,
    output logic             launch,
    input  logic             puf_resp,
    output logic             crp_valid,
    input  logic             crp_ready,
    output logic [N-1:0]     crp_challenge,
    output logic             crp_response,
    output logic             crp_stable,
    output logic [CNT_W-1:0] crp_count,
    output logic             busy,
    output logic             done
);
    localparam int c_ones_w = $clog2(REPS + 1);
    localparam int c_wait_w = $clog2(SETTLE + 1);

    localparam logic [c_ones_w-1:0] c_last_rep   = c_ones_w'(REPS - 1);
    localparam logic [c_ones_w-1:0] c_half       = c_ones_w'(REPS / 2);
    localparam logic [c_ones_w-1:0] c_all        = c_ones_w'(REPS);
    localparam logic [c_wait_w-1:0] c_settle_end = c_wait_w'(SETTLE - 1);
    localparam logic [CNT_W-1:0]    c_num_crp    = CNT_W'(NUM_CRP);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_LAUNCH  = 3'd2,
        S_WAIT    = 3'd3,
        S_SAMPLE  = 3'd4,
        S_RELAX   = 3'd5,
        S_OUTPUT  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [N-1:0]        r_chal;
    logic [c_ones_w-1:0] r_ones;
    logic [c_ones_w-1:0] r_rep;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_inc;
    logic                r_sync_meta;
    logic                r_resp_sync;

    assign w_count_inc = r_count + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_LAUNCH;
            S_LAUNCH:  w_next = S_WAIT;
            S_WAIT:    if (r_wait_cnt == c_settle_end) w_next = S_SAMPLE;
            S_SAMPLE:  w_next = (r_rep == c_last_rep) ? S_OUTPUT : S_RELAX;
            S_RELAX:   w_next = S_LAUNCH;
            S_OUTPUT: begin
                if (crp_ready) begin
                    if ((NUM_CRP != 0) && (w_count_inc == c_num_crp)) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_CAPTURE;
                    end
                end
            end
            S_DONE:    if (start) w_next = S_CAPTURE;
            default:   w_next = S_IDLE;
        endcase
    end

    // The arbiter output is asynchronous; only the second flop feeds the vote.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_meta <= 1'b0;
            r_resp_sync <= 1'b0;
        end else begin
            r_sync_meta <= puf_resp;
            r_resp_sync <= r_sync_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_chal     <= '0;
            r_ones     <= '0;
            r_rep      <= '0;
            r_wait_cnt <= '0;
            r_count    <= '0;
        end else begin
            case (r_state)
                S_CAPTURE: begin
                    r_chal <= c_bits_in;
                    r_ones <= '0;
                    r_rep  <= '0;
                end
                S_LAUNCH:  r_wait_cnt <= '0;
                S_WAIT:    r_wait_cnt <= r_wait_cnt + c_wait_w'(1);
                S_SAMPLE: begin
                    r_ones <= r_ones + c_ones_w'(r_resp_sync);
                    r_rep  <= r_rep + c_ones_w'(1);
                end
                S_OUTPUT:  if (crp_ready) r_count <= w_count_inc;
                S_DONE:    if (start) r_count <= '0;
                default: ;
            endcase
        end
    end

    // Every output is a register or a pure decode of r_state, so ready never reaches valid.
    assign chal_out      = r_chal;
    assign crp_challenge = r_chal;
    assign launch        = (r_state == S_LAUNCH);
    assign crp_valid     = (r_state == S_OUTPUT);
    assign crp_response  = crp_valid && (r_ones > c_half);
    assign crp_stable    = crp_valid && ((r_ones == '0) || (r_ones == c_all));
    assign crp_count     = r_count;
    assign done          = (r_state == S_DONE);
    assign busy          = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule
`default_nettype wire
